multicycle_data_path: RTL and testbench
=======================================

Name: multicycle_data_path

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- Owns PC, IR, register file, ALU and its own sequencing FSM, so no external control signals are needed.
- Talks to one unified instruction/data memory over a single req/ready handshake, which tolerates wait states.
- Adds a halt-on-illegal-opcode state and a retire pulse for the bench.

Parameters:
- DATA_W, 32, datapath and register width; must be ≥32; instruction word is always 32 bits, taken from mem_rdata[31:0].
- ADDR_W, 32, memory byte-address width; PC width.
- REG_COUNT, 32, number of architectural registers, power of two ≤32; a register index ≥REG_COUNT reads 0 and its write is dropped.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  transaction completes in the cycle sampled high with mem_req=1
- instr_done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  high in HALT state
- pc_out  out  ADDR_W  current PC (debug)

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC; IR, A, B, ALUOut, MDR, all registers = 0; state FETCH.
  - mem_req, mem_we, instr_done, halted = 0 immediately, even mid-transaction.
  - First request is issued in the first clock after rst rises.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ready=1.
  - mem_req deasserts the following cycle.
  - Zero-wait memory (ready in the same cycle as req) costs 1 cycle per access.
  - mem_ready with mem_req=0 is ignored.
- FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH:
  - req read at PC.
  - On ready: IR <= rdata[31:0], PC <= PC+4 (mod 2^ADDR_W), go to DECODE.
- DECODE:
  - A <= reg[rs], B <= reg[rt]; branch target = PC + (sext(imm16)<<2).
  - Unknown opcode, or R-type with an unknown func → HALT.
  - Otherwise → EXECUTE.
- EXECUTE:
  - R-type add/sub/and/or/slt on A,B; slt is signed; ALUOut latched → WRITEBACK.
  - addi/slti: A op sext(imm) → WRITEBACK.
  - lw/sw: ALUOut = A + sext(imm) → MEMORY.
  - beq: if A==B then PC <= target; retire → FETCH.
  - j: PC <= {PC[ADDR_W-1:28], imm26, 2'b00}; retire → FETCH.
  - jal: same PC update, and reg[31] <= old PC+4 (zero-extended); retire → FETCH.
  - jr: PC <= A[ADDR_W-1:0]; retire → FETCH.
- MEMORY:
  - lw: read at ALUOut[ADDR_W-1:0]; on ready MDR <= rdata → WRITEBACK.
  - sw: write B; on ready retire → FETCH.
- WRITEBACK:
  - Destination is reg[rd] for R-type, reg[rt] for I-type; value is ALUOut, or MDR for lw.
  - Retire → FETCH.
- Register 0 always reads 0; writes to it are discarded.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- Immediates are sign-extended to DATA_W.
- Minimum latencies at zero wait: R/addi/slti 4, lw 5, sw 4, beq/j/jal/jr 3 cycles; each memory wait cycle adds 1.
- instr_done pulses in the cycle the retiring state transitions back to FETCH.
- HALT: halted=1, no further requests, PC frozen at the illegal instruction + 4; left only via reset.
- Misaligned addresses are passed through unmodified; alignment is the memory's responsibility.

Decomposition:
- Package mc_defs: opcode constants (R=0, J=2, JAL=3, BEQ=4, ADDI=8, SLTI=10, LW=35, SW=43), func constants (JR=8, ADD=32, SUB=34, AND=36, OR=37, SLT=42), state encoding, and the 3-bit ALU op codes shared with alu.
- One sub-module: mc_register_file, parameterised by DATA_W and REG_COUNT, with two async read ports, one sync write port, async active-low clear, and r0 hardwired to 0.

Test Plan:
- Reset/fetch: RESET_PC=0x40, zero-wait memory; rst low then high → first mem_req with mem_addr=0x40 in the cycle after release; pc_out=0x44 after ready.
- Arithmetic: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 → r3=2, r4=1; instr_done pulses at cycles 4, 8, 12, 16.
- Wait states: mem_ready delayed 3 cycles on every access during lw r5,8(r0), with mem[8]=0xDEADBEEF → mem_req/addr stable across the wait, r5=0xDEADBEEF, instruction takes 11 cycles; sw r5,12(r0) writes 0xDEADBEEF to address 12.
- Control flow: beq r1,r1,+2 at 0x0 → next fetch at 0xC; jal at 0x10 to 0x100 → r31=0x14, next fetch at 0x100; jr r31 → next fetch at 0x14.
- r0 and halt: addi r0,r0,7 → r0 still 0; opcode 0x3F → halted=1 after DECODE, no further mem_req; rst low → halted=0.
- Async reset during a pending lw wait → mem_req drops in the same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mc_defs_pkg.sv
// Shared opcode/func encodings, FSM states and ALU op codes for the multi-cycle datapath.
package mc_defs;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] LINK_REG = 5'd31;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  // True for every opcode/func combination the datapath implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] func);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_t alu_sel(input logic [5:0] op, input logic [5:0] func);
    alu_op_t sel;
    sel = ALU_ADD;
    if (op == OP_R) begin
      case (func)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end else if (op == OP_SLTI) begin
      sel = ALU_SLT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_register_file.sv
// Architectural register file: two async read ports, one sync write port, r0 and out-of-range indices read 0.
module mc_register_file
  import mc_defs::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra_addr,
  output logic [DATA_W-1:0]    ra_data_c,
  input  logic [REG_IDX_W-1:0] rb_addr,
  output logic [DATA_W-1:0]    rb_data_c,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data
);

  localparam int unsigned IDX_W = $clog2(REG_COUNT);

  logic [DATA_W-1:0] regs [REG_COUNT];

  function automatic logic usable(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < (REG_IDX_W + 1)'(REG_COUNT));
  endfunction

  assign ra_data_c = usable(ra_addr) ? regs[ra_addr[IDX_W-1:0]] : '0;
  assign rb_data_c = usable(rb_addr) ? regs[rb_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && usable(wr_addr)) begin
      regs[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle MIPS-subset datapath with its own sequencer and a single req/ready memory port.
module multicycle_data_path
  import mc_defs::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       REG_COUNT = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              instr_done,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;

  logic [5:0]           opcode, func;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic [15:0]          imm16;
  logic [25:0]          imm26;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign func   = ir[5:0];
  assign imm16  = ir[15:0];
  assign imm26  = ir[25:0];
  assign pc_out = pc;

  logic [DATA_W-1:0] imm_sext, op_b, alu_res, rf_a, rf_b, wr_data;
  logic [ADDR_W-1:0] br_target, j_target, next_pc;
  logic              is_ctrl, wr_en;
  logic [REG_IDX_W-1:0] wr_addr;
  alu_op_t           alu_op;

  assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign br_target = pc + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc[ADDR_W-1:28], imm26, 2'b00};
  assign is_ctrl   = (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_JAL) ||
                     ((opcode == OP_R) && (func == FN_JR));

  // ALU: R-type uses B, every I-type uses the sign-extended immediate.
  always_comb begin
    alu_op  = alu_sel(opcode, func);
    op_b    = (opcode == OP_R) ? b : imm_sext;
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a + op_b;
      ALU_SUB: alu_res = a - op_b;
      ALU_AND: alu_res = a & op_b;
      ALU_OR:  alu_res = a | op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // PC already holds the fall-through address (old PC + 4) once DECODE is reached.
  always_comb begin
    next_pc = pc;
    case (opcode)
      OP_BEQ:        next_pc = (a == b) ? br_target : pc;
      OP_J, OP_JAL:  next_pc = j_target;
      OP_R:          next_pc = ADDR_W'(a);
      default:       next_pc = pc;
    endcase
  end

  // Register write: link on jal during EXECUTE, normal results in WRITEBACK.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = (opcode == OP_R) ? rd : rt;
    wr_data = (opcode == OP_LW) ? mdr : alu_out;
    if (state == S_EXECUTE && opcode == OP_JAL) begin
      wr_en   = 1'b1;
      wr_addr = LINK_REG;
      wr_data = DATA_W'(pc);
    end else if (state == S_WRITEBACK) begin
      wr_en = 1'b1;
    end
  end

  mc_register_file #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .ra_addr   (rs),
    .ra_data_c (rf_a),
    .rb_addr   (rt),
    .rb_data_c (rf_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      alu_out    <= '0;
      mdr        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here without a request already raised.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata[31:0];
            pc      <= pc + ADDR_W'(4);
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a <= rf_a;
          b <= rf_b;
          if (is_legal(opcode, func)) begin
            state <= S_EXECUTE;
          end else begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        end
        S_EXECUTE: begin
          alu_out <= alu_res;
          if (is_ctrl) begin
            pc         <= next_pc;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= next_pc;
            instr_done <= 1'b1;
            state      <= S_FETCH;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            mem_req   <= 1'b1;
            mem_we    <= (opcode == OP_SW);
            mem_addr  <= ADDR_W'(alu_res);
            mem_wdata <= b;
            state     <= S_MEMORY;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (mem_req && mem_ready) begin
            if (opcode == OP_LW) begin
              mem_req <= 1'b0;
              mdr     <= mem_rdata;
              state   <= S_WRITEBACK;
            end else begin
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= pc;
              instr_done <= 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_WRITEBACK: begin
          mem_req    <= 1'b1;
          mem_we     <= 1'b0;
          mem_addr   <= pc;
          instr_done <= 1'b1;
          state      <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: zero-wait and wait-state memory, control flow, halt and async reset.
module tb_multicycle_data_path;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, instr_done, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] mem [0:127];
  int          wait_n = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        req_h [0:63];
  logic        we_h  [0:63];
  logic        done_h[0:63];
  logic        halt_h[0:63];
  logic [31:0] addr_h[0:63];
  logic [31:0] pc_h  [0:63];
  logic [31:0] fetch_q[$];
  int          done_cnt;

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  multicycle_data_path #(.RESET_PC(32'h40)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .instr_done (instr_done),
    .halted     (halted),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = ILLEGAL;
  endtask

  // Cycle 0 is the first negedge after release, i.e. the first cycle with a request up.
  task automatic run(input int n);
    fetch_q.delete();
    done_cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req_h[c]  = mem_req;
      we_h[c]   = mem_we;
      done_h[c] = instr_done;
      halt_h[c] = halted;
      addr_h[c] = mem_addr;
      pc_h[c]   = pc_out;
      if (instr_done) done_cnt++;
      if (mem_req && mem_ready && !mem_we) fetch_q.push_back(mem_addr);
    end
  endtask

  initial begin
    int cnt;
    int w0;
    logic [31:0] exp_fetch [6];

    // Phase 1: reset, arithmetic, r0 write, illegal opcode
    clear_mem();
    mem[32'h40 >> 2] = enc_i(6'd8, 5'd0, 5'd1, 16'd5);
    mem[32'h44 >> 2] = enc_i(6'd8, 5'd0, 5'd2, 16'hFFFD);
    mem[32'h48 >> 2] = enc_r(6'd32, 5'd1, 5'd2, 5'd3);
    mem[32'h4C >> 2] = enc_r(6'd42, 5'd2, 5'd1, 5'd4);
    mem[32'h50 >> 2] = enc_i(6'd8, 5'd0, 5'd0, 16'd7);
    mem[32'h54 >> 2] = 32'hFC00_0000;
    wait_n = 0;
    repeat (2) @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_instr_done", 32'(instr_done), 32'd0);
    check("reset_pc", pc_out, 32'h40);
    rst = 1'b1;
    run(30);
    check("first_req", 32'(req_h[0]), 32'd1);
    check("first_addr", addr_h[0], 32'h40);
    check("pc_after_fetch", pc_h[1], 32'h44);
    for (int i = 1; i <= 5; i++) check($sformatf("done_c%0d", 4 * i), 32'(done_h[4 * i]), 32'd1);
    check("done_count_p1", 32'(done_cnt), 32'd5);
    check("r1", dut.u_rf.regs[1], 32'd5);
    check("r2", dut.u_rf.regs[2], 32'hFFFF_FFFD);
    check("r3_add", dut.u_rf.regs[3], 32'd2);
    check("r4_slt", dut.u_rf.regs[4], 32'd1);
    check("r0_zero", dut.u_rf.regs[0], 32'd0);
    check("halted_after_decode", {30'd0, halt_h[21], halt_h[22]}, 32'd1);
    cnt = 0;
    for (int c = 22; c < 30; c++) if (req_h[c]) cnt++;
    check("no_req_in_halt", 32'(cnt), 32'd0);
    check("halt_pc", pc_out, 32'h58);
    rst = 1'b0;
    #1;
    check("halt_cleared_by_reset", 32'(halted), 32'd0);

    // Phase 2: lw/sw with three wait states on every access
    clear_mem();
    mem[32'h40 >> 2] = enc_i(6'd35, 5'd0, 5'd5, 16'd8);
    mem[32'h44 >> 2] = enc_i(6'd43, 5'd0, 5'd5, 16'd12);
    mem[8 >> 2]      = 32'hDEAD_BEEF;
    wait_n = 3;
    @(negedge clk);
    w0  = wr_cnt;
    rst = 1'b1;
    run(32);
    cnt = 0;
    for (int c = 0; c < 4; c++) if (req_h[c] && !we_h[c] && addr_h[c] == 32'h40) cnt++;
    for (int c = 6; c < 10; c++) if (req_h[c] && !we_h[c] && addr_h[c] == 32'h8) cnt++;
    check("req_addr_stable", 32'(cnt), 32'd8);
    check("lw_retire_c11", 32'(done_h[11]), 32'd1);
    check("sw_retire_c21", 32'(done_h[21]), 32'd1);
    check("done_count_p2", 32'(done_cnt), 32'd2);
    check("r5_lw", dut.u_rf.regs[5], 32'hDEAD_BEEF);
    check("sw_count", 32'(wr_cnt - w0), 32'd1);
    check("sw_addr", last_waddr, 32'd12);
    check("sw_data", last_wdata, 32'hDEAD_BEEF);
    check("halt_p2", 32'(halted), 32'd1);

    // Phase 3: async reset while a lw is waiting on memory
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(8);
    check("lw_pending_req", 32'(req_h[7]), 32'd1);
    check("lw_pending_addr", addr_h[7], 32'h8);
    rst = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("regs_cleared", dut.u_rf.regs[5], 32'd0);

    // Phase 4: j / beq / jal / jr, restarting at RESET_PC
    clear_mem();
    mem[32'h40 >> 2]  = enc_j(6'd2, 26'd0);
    mem[32'h00 >> 2]  = enc_i(6'd4, 5'd1, 5'd1, 16'd2);
    mem[32'h0C >> 2]  = enc_i(6'd8, 5'd0, 5'd6, 16'd9);
    mem[32'h10 >> 2]  = enc_j(6'd3, 26'h40);
    mem[32'h100 >> 2] = enc_r(6'd8, 5'd31, 5'd0, 5'd0);
    wait_n = 0;
    @(negedge clk);
    rst = 1'b1;
    run(24);
    exp_fetch = '{32'h40, 32'h0, 32'hC, 32'h10, 32'h100, 32'h14};
    check("fetch_count", 32'(fetch_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < fetch_q.size()) check($sformatf("fetch_%0d", i), fetch_q[i], exp_fetch[i]);
      else check($sformatf("fetch_%0d_missing", i), 32'hFFFF_FFFF, exp_fetch[i]);
    end
    check("jal_link_r31", dut.u_rf.regs[31], 32'h14);
    check("r6_after_branch", dut.u_rf.regs[6], 32'd9);
    check("halt_p4", 32'(halted), 32'd1);
    check("halt_pc_p4", pc_out, 32'h18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
